sextium_mem_arbiter: RTL
========================

SEXTIUM_MEM_ARBITER -- requirements
Module: sextium_mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data word width.
REQ-002 Parameter ADDR_W, default 16, SHALL set the address width.
REQ-003 Parameter MEM_LAT, default 1, legal 1..4, SHALL set the cycles a memory strobe is held before read data is captured.
REQ-004 Ports SHALL be, clock and reset first, as follows:
  clock      in   1               single system clock, rising edge
  reset      in   1               synchronous, active-high
  req        in   2               per-requester access request; bit 0 = core, bit 1 = loader/DMA
  we         in   2               per-requester write enable; 1 = write, 0 = read
  addr       in   2*ADDR_W        per-requester address, requester n in slice n
  wdata      in   2*DATA_W        per-requester write data, requester n in slice n
  ack        out  2               one-cycle completion pulse for requester n
  rdata      out  DATA_W          read result, valid when ack pulses for a read
  mem_read   out  1               memory read strobe
  mem_write  out  1               memory write strobe
  mem_addr   out  ADDR_W          memory address
  mem_wdata  out  DATA_W          memory write data
  mem_rdata  in   DATA_W          memory read data, valid by the last strobe cycle

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-006 In IDLE with req==0, the FSM SHALL stay in IDLE with all strobes low.
REQ-007 In IDLE with exactly one req bit set, that requester SHALL be granted.
REQ-008 In IDLE with req==2'b11, the requester other than last_grant SHALL be granted (round-robin).
REQ-009 On a grant, the grant index, we, addr slice and wdata slice SHALL be latched, and the FSM SHALL enter ACCESS on the next cycle.
REQ-010 In ACCESS, exactly one of mem_read/mem_write SHALL be high, per the latched we, for exactly MEM_LAT consecutive cycles, counted by a down-counter.
REQ-011 mem_addr and mem_wdata SHALL equal the latched values throughout ACCESS.
REQ-012 In IDLE and RESP, mem_addr and mem_wdata SHALL be 0.
REQ-013 For a read, mem_rdata SHALL be registered into rdata on the last ACCESS cycle.
REQ-014 A write SHALL leave rdata unchanged.
REQ-015 In RESP, ack[grant] SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE, and last_grant SHALL be updated to the grant index.
REQ-016 Latency: req seen in IDLE at cycle t SHALL produce strobes at t+1..t+MEM_LAT and ack at t+MEM_LAT+1.
REQ-017 Throughput SHALL be one transaction per MEM_LAT+2 cycles.
REQ-018 req SHALL be ignored in ACCESS and RESP; latched operands SHALL not change during a transaction.
REQ-019 A requester that drops req mid-transaction SHALL still receive its ack; the transaction SHALL not abort.
REQ-020 A requester whose req is still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-021 ack SHALL never have both bits set.
REQ-022 mem_read and mem_write SHALL never be high together.
REQ-023 ack SHALL never pulse without a preceding strobe.

Reset
REQ-024 On reset, the following SHALL be forced at the next rising clock edge: state=IDLE, ack=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, rdata=0, counter=0, last_grant=1 (so the core wins the first tie).
REQ-025 Reset asserted mid-ACCESS or in RESP SHALL drop strobes on the next edge, emit no ack and discard the transaction.

Structure
REQ-026 The state enum, default DATA_W/ADDR_W and the MEM_LAT range limits SHALL live in shared package sextium_mem_pkg.
REQ-027 Two-way round-robin selection SHALL be a sub-module, sextium_rr_arbiter (inputs req[1:0] and last_grant; outputs grant index and valid), combinational.

Verification
REQ-028 Single read: MEM_LAT=1; core reads addr 0x0010 with mem holding 0xBEEF -> mem_read high 1 cycle with mem_addr=0x0010; ack=2'b01 two cycles after req; rdata=0xBEEF.
REQ-029 Single write: loader writes 0x1234 to 0x00FF -> mem_write high 1 cycle with mem_addr=0x00FF and mem_wdata=0x1234; ack=2'b10; rdata unchanged.
REQ-030 Contention: both requesters hold req continuously for 4 transactions -> grant order core, loader, core, loader; each ack spaced 3 cycles apart.
REQ-031 Latency: MEM_LAT=3 read -> mem_read high exactly 3 cycles; ack at t+4; rdata equals mem_rdata from the third strobe cycle.
REQ-032 Early drop: core drops req the cycle after grant -> strobe still completes and ack[0] still pulses once.
REQ-033 Reset mid-ACCESS (MEM_LAT=3, reset on the 2nd strobe cycle) -> strobes low next cycle, no ack, all outputs 0; next tie after reset granted to core.

Source files
------------

// File: rtl/sextium_mem_pkg.sv
// Shared definitions for the Sextium two-requester memory arbiter:
// FSM state encoding, default widths and the legal memory-latency range.
package sextium_mem_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // One-hot acknowledge vector for a granted requester index.
    function automatic logic [1:0] ack_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sextium_rr_arbiter.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes
// to the requester that was not granted last time.
module sextium_rr_arbiter (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    // Pick the winning requester from the current request vector.
    always_comb begin
        grant = 1'b0;
        valid = 1'b0;
        case (req)
            2'b01: begin
                grant = 1'b0;
                valid = 1'b1;
            end
            2'b10: begin
                grant = 1'b1;
                valid = 1'b1;
            end
            2'b11: begin
                grant = ~last_grant;
                valid = 1'b1;
            end
            default: begin
                grant = 1'b0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sextium_mem_arbiter.sv
// Arbitrates a core and a loader/DMA onto one memory port: grant in IDLE,
// hold the strobe for MEM_LAT cycles in ACCESS, pulse ack in RESP.
module sextium_mem_arbiter
    import sextium_mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int MEM_LAT = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_grant;
    logic                r_we;
    logic                r_last_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_grant;
    logic                w_valid;
    logic                w_we_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic [1:0]          w_ack_nxt;
    logic                w_mem_read_nxt;
    logic                w_mem_write_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;

    logic [1:0]          r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    sextium_rr_arbiter u_rr (
        .req        (req),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .valid      (w_valid)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operands as they will be latched: fresh slice on a grant, held otherwise.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_we_nxt    = we[w_grant];
            w_addr_nxt  = w_grant ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
            w_wdata_nxt = w_grant ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
        end else begin
            w_we_nxt    = r_we;
            w_addr_nxt  = r_addr;
            w_wdata_nxt = r_wdata;
        end
    end

    // Output decode from the upcoming state so every port leaves a flop.
    always_comb begin
        w_ack_nxt       = 2'b00;
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        case (w_state_nxt)
            ST_ACCESS: begin
                w_mem_read_nxt  = ~w_we_nxt;
                w_mem_write_nxt = w_we_nxt;
                w_mem_addr_nxt  = w_addr_nxt;
                w_mem_wdata_nxt = w_wdata_nxt;
            end
            ST_RESP: begin
                w_ack_nxt = ack_onehot(r_grant);
            end
            default: begin
                w_ack_nxt = 2'b00;
            end
        endcase
    end

    // Transaction latch, strobe down-counter and round-robin history.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= '0;
            r_grant      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_cnt   <= CNT_W'(MEM_LAT);
                        r_grant <= w_grant;
                        r_we    <= w_we_nxt;
                        r_addr  <= w_addr_nxt;
                        r_wdata <= w_wdata_nxt;
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_RESP: begin
                    r_last_grant <= r_grant;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Output registers; read data is captured at the end of the last strobe cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ack       <= 2'b00;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_ack       <= w_ack_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            if (r_state == ST_ACCESS && r_cnt == CNT_W'(1) && !r_we) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
